mc_ctrl_fsm: RTL

Parametrised main control FSM for the multicycle ARM datapath. It sequences fetch, decode, execute, memory and writeback for data-processing, multiply, LDR/STR and B instructions. It adds three things to the base controller: a memory ready handshake, a multi-cycle multiply path, and a sticky illegal-opcode trap. It sits in the controller beside the decoder and ALU decoder and drives the datapath multiplexer selects and write enables.

---
 rtl/mc_ctrl_fsm.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle ARM datapath: fetch/decode/execute/memory/writeback
// sequencing with a memory ready handshake, a multi-cycle multiply path and a sticky illegal-opcode trap.
module mc_ctrl_fsm #(
  parameter int MUL_LATENCY   = 3,  // 1..16
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       mem_ready,
  output logic       NextPC,
  output logic       Branch,
  output logic       MemW,
  output logic       RegW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic       MulStart,
  output logic       Retire,
  output logic       Illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10,
    MULEXEC  = 4'd11,
    MULWB    = 4'd12
  } state_e;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_e     cur_state;
  state_e     nxt_state;
  logic [3:0] mul_cnt;
  logic       ready;

  // Only the load/store direction bit and the immediate bit steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = cur_state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= FETCH;
      mul_cnt   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == DECODE && nxt_state == MULEXEC) begin
        mul_cnt <= MUL_LOAD;
      end else if (cur_state == MULEXEC && mul_cnt != 4'd0) begin
        mul_cnt <= mul_cnt - 4'd1;
      end
    end
  end

  // NOTE: every output and the next state get a default first, so no path can infer a latch.
  always_comb begin
    nxt_state = FETCH;
    NextPC    = 1'b0;
    Branch    = 1'b0;
    MemW      = 1'b0;
    RegW      = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 1'b0;
    MulStart  = 1'b0;
    Retire    = 1'b0;
    Illegal   = 1'b0;

    case (cur_state)
      FETCH: begin
        nxt_state = ready ? DECODE : FETCH;
        ResultSrc = 2'b10;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        IRWrite   = ready;
        NextPC    = ready;
      end
      DECODE: begin
        ResultSrc = 2'b10;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        case (Op)
          2'b00:   nxt_state = IsMul ? MULEXEC : (Funct[5] ? EXECUTEI : EXECUTER);
          2'b01:   nxt_state = MEMADR;
          2'b10:   nxt_state = BRANCH;
          default: nxt_state = UNKNOWN;
        endcase
      end
      MEMADR: begin
        nxt_state = Funct[0] ? MEMREAD : MEMWRITE;
        ALUSrcB   = 2'b01;
      end
      MEMREAD: begin
        nxt_state = ready ? MEMWB : MEMREAD;
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b01;
        Retire    = 1'b1;
      end
      MEMWRITE: begin
        nxt_state = ready ? FETCH : MEMWRITE;
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
        Retire    = ready;
      end
      EXECUTER: begin
        nxt_state = ALUWB;
        ALUOp     = 1'b1;
      end
      EXECUTEI: begin
        nxt_state = ALUWB;
        ALUOp     = 1'b1;
        ALUSrcB   = 2'b01;
      end
      ALUWB: begin
        RegW   = 1'b1;
        Retire = 1'b1;
      end
      BRANCH: begin
        Branch    = 1'b1;
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b01;
        Retire    = 1'b1;
      end
      UNKNOWN: begin
        nxt_state = UNKNOWN;
        Illegal   = 1'b1;
      end
      MULEXEC: begin
        nxt_state = (mul_cnt == 4'd0) ? MULWB : MULEXEC;
        // The counter sits at its load value only in the first MULEXEC cycle.
        MulStart  = (mul_cnt == MUL_LOAD);
      end
      MULWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b11;
        Retire    = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
  end

endmodule
